// File: rtl/pulsacion_pkg.sv
// pulsacion_pkg: state encoding and 12 MHz default timing for the press classifier
package pulsacion_pkg;
  typedef enum logic [2:0] {REPOSO, PRESION1, ESPERA_DOBLE, PRESION2, MANTENIDO} estado_t;
  localparam int CICLOS_LARGA_DEF      = 12_000_000;
  localparam int CICLOS_DOBLE_DEF      = 3_600_000;
  localparam int CICLOS_REPETICION_DEF = 2_400_000;
  localparam int ANCHO_CONT_DEF        = 24;
endpackage

// File: rtl/detector_flanco.sv
// detector_flanco: rising-edge strobe; prev resets high so a button held through reset is ignored
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic senal_i,
  output logic flanco_o
);
  logic prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= senal_i;
  end
  assign flanco_o = senal_i && !prev_q;
endmodule

// File: rtl/clasificador_pulsacion.sv
// clasificador_pulsacion: turns the debounced button level into short/double/long/repeat pulses
module clasificador_pulsacion
  import pulsacion_pkg::*;
#(
  parameter int CICLOS_LARGA      = CICLOS_LARGA_DEF,
  parameter int CICLOS_DOBLE      = CICLOS_DOBLE_DEF,
  parameter int CICLOS_REPETICION = CICLOS_REPETICION_DEF,
  parameter int ANCHO_CONT        = ANCHO_CONT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic senal_limpia,
  output logic pulso_corto,
  output logic pulso_doble,
  output logic pulso_largo,
  output logic pulso_repeticion,
  output logic ocupado
);
  localparam logic [ANCHO_CONT-1:0] FIN_LARGA = ANCHO_CONT'(CICLOS_LARGA - 1);
  localparam logic [ANCHO_CONT-1:0] FIN_DOBLE = ANCHO_CONT'(CICLOS_DOBLE - 1);
  localparam logic [ANCHO_CONT-1:0] FIN_REP   = ANCHO_CONT'(CICLOS_REPETICION - 1);

  estado_t estado_q, estado_d;
  logic [ANCHO_CONT-1:0] cont_q, cont_d;
  logic corto_q, corto_d, doble_q, doble_d, largo_q, largo_d, rep_q, rep_d, ocupado_q, ocupado_d;
  logic flanco;

  detector_flanco u_flanco (
    .clk      (clk),
    .rst_n    (rst_n),
    .senal_i  (senal_limpia),
    .flanco_o (flanco)
  );

  // Release beats the long threshold and a new edge beats window expiry by branch order.
  always_comb begin
    estado_d = estado_q;
    corto_d  = 1'b0;
    doble_d  = 1'b0;
    largo_d  = 1'b0;
    rep_d    = 1'b0;
    case (estado_q)
      REPOSO:       estado_d = flanco ? PRESION1 : REPOSO;
      PRESION1:     if (!senal_limpia) estado_d = ESPERA_DOBLE;
                    else if (cont_q == FIN_LARGA) begin estado_d = MANTENIDO; largo_d = 1'b1; end
      ESPERA_DOBLE: if (flanco) estado_d = PRESION2;
                    else if (cont_q == FIN_DOBLE) begin estado_d = REPOSO; corto_d = 1'b1; end
      PRESION2:     if (!senal_limpia) begin estado_d = REPOSO; doble_d = 1'b1; end
      MANTENIDO:    if (!senal_limpia) estado_d = REPOSO;
                    else rep_d = (cont_q == FIN_REP);
      default:      estado_d = REPOSO;
    endcase
    cont_d    = (estado_d != estado_q || rep_d || estado_q == REPOSO || estado_q == PRESION2)
                ? '0 : cont_q + ANCHO_CONT'(1);
    // Stays high through the first REPOSO cycle so busy covers the final pulse.
    ocupado_d = (estado_q != REPOSO) || (estado_d != REPOSO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= REPOSO;
      cont_q    <= '0;
      corto_q   <= 1'b0;
      doble_q   <= 1'b0;
      largo_q   <= 1'b0;
      rep_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      corto_q   <= corto_d;
      doble_q   <= doble_d;
      largo_q   <= largo_d;
      rep_q     <= rep_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign pulso_corto      = corto_q;
  assign pulso_doble      = doble_q;
  assign pulso_largo      = largo_q;
  assign pulso_repeticion = rep_q;
  assign ocupado          = ocupado_q;
endmodule

// File: tb/tb_clasificador_pulsacion.sv
// tb_clasificador_pulsacion: table-driven scenarios, reset sequence and randomized run against a timeline model
module tb_clasificador_pulsacion;
  localparam int L = 20, D = 10, R = 5, NMAX = 900;

  logic clk = 1'b0, rst_n, senal;
  logic corto, doble, largo, rep, ocup;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  clasificador_pulsacion #(
    .CICLOS_LARGA(L), .CICLOS_DOBLE(D), .CICLOS_REPETICION(R), .ANCHO_CONT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .senal_limpia(senal),
    .pulso_corto(corto), .pulso_doble(doble), .pulso_largo(largo),
    .pulso_repeticion(rep), .ocupado(ocup)
  );

  typedef struct {
    string nombre;
    int hi1, lo, hi2;
    int n_corto, n_doble, n_largo, n_rep;
    int primero, fin;
  } caso_t;

  caso_t casos[10];
  bit in_s[NMAX];
  logic [4:0] exp_o[NMAX+64];
  bit st[NMAX+64];
  bit p0;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic paso(input bit v, output logic [4:0] o);
    @(negedge clk);
    o = {corto, doble, largo, rep, ocup};
    senal = v;
  endtask

  // k = 0 is the cycle in which the first rising edge is sampled
  task automatic aplicar(input caso_t c);
    logic [4:0] o;
    int nc, nd, nl, nr, primero, fin, inicio, multi;
    bit v;
    nc = 0; nd = 0; nl = 0; nr = 0; primero = -1; fin = -1; inicio = -1; multi = 0;
    for (int k = 0; k < 90; k++) begin
      v = (k < c.hi1) || (c.hi2 > 0 && k >= c.hi1 + c.lo && k < c.hi1 + c.lo + c.hi2);
      paso(v, o);
      nc += int'(o[4]); nd += int'(o[3]); nl += int'(o[2]); nr += int'(o[1]);
      if (|o[4:1] && primero < 0) primero = k;
      if ($countones(o[4:1]) > 1) multi++;
      if (o[0] && inicio < 0) inicio = k;
      if (o[0]) fin = k + 1;
    end
    chk({c.nombre, " cuentas"}, nc * 1000 + nd * 100 + nl * 10 + nr,
        c.n_corto * 1000 + c.n_doble * 100 + c.n_largo * 10 + c.n_rep);
    chk({c.nombre, " primer_pulso"}, primero, c.primero);
    chk({c.nombre, " ocupado_fin"}, fin, c.fin);
    chk({c.nombre, " ocupado_inicio"}, inicio, 1);
    chk({c.nombre, " pulsos_simultaneos"}, multi, 0);
  endtask

  function automatic bit nivel(input int c, input int n);
    return (c < 0) ? p0 : (c >= n) ? 1'b0 : in_s[c];
  endfunction

  function automatic bit flanco_en(input int c, input int n);
    return nivel(c, n) && !nivel(c - 1, n);
  endfunction

  // Expected timeline derived from press/release instants rather than a cycle-by-cycle machine
  task automatic modelo(input int n);
    int i, t, r, e, g, f, fin_st;
    for (int c = 0; c < NMAX + 64; c++) begin exp_o[c] = '0; st[c] = 1'b0; end
    i = 0;
    while (i < n) begin
      t = -1;
      for (int c = i; c < n; c++) if (flanco_en(c, n)) begin t = c; break; end
      if (t < 0) break;
      r = t + 1;
      while (r <= t + L && nivel(r, n)) r++;
      if (r <= t + L) begin
        e = -1;
        for (int c = r + 1; c <= r + D; c++) if (flanco_en(c, n)) begin e = c; break; end
        if (e >= 0) begin
          g = e + 1;
          while (nivel(g, n)) g++;
          exp_o[g + 1][3] = 1'b1;
          fin_st = g;
        end else begin
          exp_o[r + D + 1][4] = 1'b1;
          fin_st = r + D;
        end
      end else begin
        exp_o[t + L + 1][2] = 1'b1;
        f = t + L + 1;
        while (nivel(f, n)) f++;
        for (int p = t + L + 1 + R; p - 1 < f; p += R) exp_o[p][1] = 1'b1;
        fin_st = f;
      end
      for (int c = t + 1; c <= fin_st; c++) st[c] = 1'b1;
      i = fin_st + 1;
    end
    for (int c = 0; c < NMAX + 64; c++) exp_o[c][0] = st[c] || (c > 0 && st[c - 1]);
  endtask

  initial begin
    logic [4:0] o, acc;
    int n, hi, lo, sel;
    casos[0] = '{"corto",          5,  0, 0, 1, 0, 0, 0, 16, 17};
    casos[1] = '{"corto_min",      1,  0, 0, 1, 0, 0, 0, 12, 13};
    casos[2] = '{"doble",          5,  3, 4, 0, 1, 0, 0, 13, 14};
    casos[3] = '{"largo_rep",     40,  0, 0, 0, 0, 1, 3, 21, 42};
    casos[4] = '{"lim_largo_20",  20,  0, 0, 1, 0, 0, 0, 31, 32};
    casos[5] = '{"lim_largo_21",  21,  0, 0, 0, 0, 1, 0, 21, 23};
    casos[6] = '{"lim_doble_10",   5, 10, 3, 0, 1, 0, 0, 19, 20};
    casos[7] = '{"lim_doble_11",   5, 11, 3, 2, 0, 0, 0, 16, 31};
    casos[8] = '{"doble_largo",    5,  3, 30, 0, 1, 0, 0, 39, 40};
    casos[9] = '{"tras_reset",     5,  0, 0, 1, 0, 0, 0, 16, 17};

    senal = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("reset_estado", int'({corto, doble, largo, rep, ocup}), 0);
    repeat (3) paso(1'b0, o);
    rst_n = 1'b1;
    repeat (3) paso(1'b0, o);

    for (int k = 0; k < 9; k++) aplicar(casos[k]);

    repeat (30) paso(1'b1, o);
    @(negedge clk);
    chk("pre_reset_ocupado", int'(ocup), 1);
    rst_n = 1'b0;
    #1 chk("reset_async", int'({corto, doble, largo, rep, ocup}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    acc = '0;
    for (int k = 0; k < 40; k++) begin paso(1'b1, o); acc |= o; end
    chk("mantenido_tras_reset", int'(acc), 0);
    repeat (3) paso(1'b0, o);
    aplicar(casos[9]);

    n = 0;
    while (n < NMAX - 120) begin
      sel = $urandom_range(0, 3);
      hi = (sel == 0) ? $urandom_range(1, 8) : (sel == 1) ? $urandom_range(19, 21) : $urandom_range(9, 45);
      sel = $urandom_range(0, 3);
      lo = (sel == 0) ? $urandom_range(1, 9) : (sel == 1) ? $urandom_range(9, 11) : $urandom_range(1, 16);
      for (int k = 0; k < hi; k++) in_s[n++] = 1'b1;
      for (int k = 0; k < lo; k++) in_s[n++] = 1'b0;
    end
    for (int k = 0; k < 40; k++) in_s[n++] = 1'b0;
    p0 = 1'b0;
    modelo(n);
    for (int c = 0; c < n; c++) begin
      paso(in_s[c], o);
      chk($sformatf("aleatorio ciclo %0d", c), int'(o), int'(exp_o[c]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
